// File: rtl/falafel_output_serializer.sv
// Drains the alloc-result and free-ack FIFOs and sends each entry as a two-beat
// (header, payload) response. Sources are picked round-robin; sequence number wraps.
module falafel_output_serializer #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned SEQ_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              alloc_fifo_empty_i,
  output logic              alloc_fifo_read_o,
  input  logic [DATA_W-1:0] alloc_fifo_dout_i,
  input  logic              free_fifo_empty_i,
  output logic              free_fifo_read_o,
  input  logic [DATA_W-1:0] free_fifo_dout_i,
  output logic              resp_val_o,
  input  logic              resp_rdy_i,
  output logic [DATA_W-1:0] resp_data_o,
  output logic              busy_o,
  output logic [SEQ_W-1:0]  seq_o
);

  localparam int unsigned TYPE_W    = 3;
  localparam int unsigned SEQ_LSB   = 8;
  localparam logic [TYPE_W-1:0] TYPE_ALLOC = TYPE_W'(1);
  localparam logic [TYPE_W-1:0] TYPE_FREE  = TYPE_W'(2);

  typedef enum logic [1:0] {
    IDLE,
    SEND_HDR,
    SEND_PAYLOAD
  } state_t;

  state_t            state_q, state_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic              rr_free_q, rr_free_d;   // 1: FREE source preferred on a tie
  logic              src_free_q, src_free_d; // source of the message in flight
  logic [DATA_W-1:0] payload_q, payload_d;
  logic [DATA_W-1:0] header_q, header_d;
  logic              alloc_pop_c, free_pop_c;
  logic              pick_alloc, pick_free;

  function automatic logic [DATA_W-1:0] build_header(input logic [TYPE_W-1:0] typ,
                                                     input logic [SEQ_W-1:0]  seq);
    logic [DATA_W-1:0] h;
    h                   = '0;
    h[TYPE_W-1:0]       = typ;
    h[SEQ_LSB +: SEQ_W] = seq;
    return h;
  endfunction

  // A lone non-empty source wins regardless of the pointer, so neither side can stall the other.
  always_comb begin
    pick_alloc = !alloc_fifo_empty_i && (free_fifo_empty_i || !rr_free_q);
    pick_free  = !free_fifo_empty_i && (alloc_fifo_empty_i || rr_free_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      seq_q      <= '0;
      rr_free_q  <= 1'b0;
      src_free_q <= 1'b0;
      payload_q  <= '0;
      header_q   <= '0;
    end else begin
      state_q    <= state_d;
      seq_q      <= seq_d;
      rr_free_q  <= rr_free_d;
      src_free_q <= src_free_d;
      payload_q  <= payload_d;
      header_q   <= header_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    seq_d       = seq_q;
    rr_free_d   = rr_free_q;
    src_free_d  = src_free_q;
    payload_d   = payload_q;
    header_d    = header_q;
    alloc_pop_c = 1'b0;
    free_pop_c  = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_alloc) begin
          alloc_pop_c = 1'b1;
          payload_d   = alloc_fifo_dout_i;
          src_free_d  = 1'b0;
          header_d    = build_header(TYPE_ALLOC, seq_q);
          state_d     = SEND_HDR;
        end else if (pick_free) begin
          free_pop_c  = 1'b1;
          payload_d   = free_fifo_dout_i;
          src_free_d  = 1'b1;
          header_d    = build_header(TYPE_FREE, seq_q);
          state_d     = SEND_HDR;
        end
      end
      SEND_HDR: begin
        if (resp_rdy_i) state_d = SEND_PAYLOAD;
      end
      SEND_PAYLOAD: begin
        if (resp_rdy_i) begin
          seq_d     = seq_q + SEQ_W'(1);
          rr_free_d = !src_free_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pops must land in the same IDLE cycle the FIFO is seen non-empty; held off during reset.
  assign alloc_fifo_read_o = alloc_pop_c && rst_ni;
  assign free_fifo_read_o  = free_pop_c && rst_ni;

  assign resp_val_o = (state_q != IDLE);
  assign busy_o     = (state_q != IDLE);
  assign seq_o      = seq_q;

  always_comb begin
    case (state_q)
      SEND_HDR:     resp_data_o = header_q;
      SEND_PAYLOAD: resp_data_o = payload_q;
      default:      resp_data_o = '0;
    endcase
  end

endmodule

// File: tb/tb_falafel_output_serializer.sv
// Directed bench for falafel_output_serializer with queue-modelled FWFT source FIFOs.
module tb_falafel_output_serializer;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned SEQ_W  = 8;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              alloc_fifo_empty_i, free_fifo_empty_i;
  logic              alloc_fifo_read_o, free_fifo_read_o;
  logic [DATA_W-1:0] alloc_fifo_dout_i, free_fifo_dout_i;
  logic              resp_val_o, resp_rdy_i, busy_o;
  logic [DATA_W-1:0] resp_data_o;
  logic [SEQ_W-1:0]  seq_o;

  falafel_output_serializer #(.DATA_W(DATA_W), .SEQ_W(SEQ_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .alloc_fifo_empty_i(alloc_fifo_empty_i), .alloc_fifo_read_o(alloc_fifo_read_o),
    .alloc_fifo_dout_i(alloc_fifo_dout_i),
    .free_fifo_empty_i(free_fifo_empty_i), .free_fifo_read_o(free_fifo_read_o),
    .free_fifo_dout_i(free_fifo_dout_i),
    .resp_val_o(resp_val_o), .resp_rdy_i(resp_rdy_i), .resp_data_o(resp_data_o),
    .busy_o(busy_o), .seq_o(seq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic              is_free;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] hdr;
  } vec_t;

  logic [DATA_W-1:0] aq[$], fq[$], got[$];
  int n_chk = 0, n_fail = 0, bad_pop = 0, pops_a = 0, pops_f = 0;
  logic s_ra, s_rf, s_val, s_busy;
  logic [DATA_W-1:0] s_data;
  logic [SEQ_W-1:0]  s_seq;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic refresh();
    alloc_fifo_empty_i = (aq.size() == 0);
    alloc_fifo_dout_i  = (aq.size() != 0) ? aq[0] : '0;
    free_fifo_empty_i  = (fq.size() == 0);
    free_fifo_dout_i   = (fq.size() != 0) ? fq[0] : '0;
  endtask

  // Sample at negedge (what the next posedge will act on), then apply pops after the edge.
  task automatic tick();
    @(negedge clk_i);
    s_ra = alloc_fifo_read_o; s_rf = free_fifo_read_o;
    s_val = resp_val_o; s_data = resp_data_o; s_busy = busy_o; s_seq = seq_o;
    if ((s_ra && aq.size() == 0) || (s_rf && fq.size() == 0) || (s_ra && s_rf)) bad_pop++;
    if (resp_val_o && resp_rdy_i) got.push_back(resp_data_o);
    @(posedge clk_i); #1;
    if (s_ra && aq.size() != 0) begin void'(aq.pop_front()); pops_a++; end
    if (s_rf && fq.size() != 0) begin void'(fq.pop_front()); pops_f++; end
    refresh();
  endtask

  task automatic run_msgs(input int n, input int limit, output int cycles);
    cycles = 0;
    while (got.size() < 2 * n && cycles < limit) begin
      tick();
      cycles++;
    end
    chk("beats_received", 64'(got.size()), 64'(2 * n));
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    aq.delete(); fq.delete(); got.delete();
    refresh();
    resp_rdy_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  vec_t vecs[4];
  int   cyc, err;

  initial begin
    vecs[0] = '{1'b0, 64'hDEAD_BEEF_0000_0001, 64'h0000_0000_0000_0101};
    vecs[1] = '{1'b1, 64'h0000_0000_0000_00A5, 64'h0000_0000_0000_0202};
    vecs[2] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0302};
    vecs[3] = '{1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0000_0000_0000_0401};

    // Reset values, sampled while reset is held
    aq.push_back(64'h55);
    refresh();
    resp_rdy_i = 1'b1;
    #12;
    chk("rst_val", 64'(resp_val_o), 64'd0);
    chk("rst_data", resp_data_o, 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_seq", 64'(seq_o), 64'd0);
    chk("rst_alloc_read", 64'(alloc_fifo_read_o), 64'd0);
    do_reset();

    // Single alloc entry: latency and beat contents
    aq.push_back(64'h0000_0000_0000_1000);
    refresh();
    tick(); chk("t1_pop", 64'(s_ra), 64'd1); chk("t1_val0", 64'(s_val), 64'd0);
    tick(); chk("t1_hdr_val", 64'(s_val), 64'd1); chk("t1_hdr", s_data, 64'h1);
    chk("t1_busy", 64'(s_busy), 64'd1); chk("t1_no_repop", 64'(s_ra), 64'd0);
    tick(); chk("t1_payload", s_data, 64'h1000); chk("t1_seq_hold", 64'(s_seq), 64'd0);
    tick(); chk("t1_idle_val", 64'(s_val), 64'd0); chk("t1_idle_busy", 64'(s_busy), 64'd0);
    chk("t1_idle_data", s_data, 64'd0);
    chk("t1_seq", 64'(s_seq), 64'd1); chk("t1_pops", 64'(pops_a), 64'd1);

    // Table of single messages, back-to-back sequence numbers
    for (int i = 0; i < 4; i++) begin
      got.delete();
      if (vecs[i].is_free) fq.push_back(vecs[i].din); else aq.push_back(vecs[i].din);
      refresh();
      run_msgs(1, 20, cyc);
      chk($sformatf("vec%0d_hdr", i), got[0], vecs[i].hdr);
      chk($sformatf("vec%0d_payload", i), got[1], vecs[i].din);
    end

    // Both FIFOs with two entries: round-robin order and peak throughput
    do_reset();
    aq.push_back(64'hA0); aq.push_back(64'hA1);
    fq.push_back(64'hF0); fq.push_back(64'hF1);
    refresh();
    run_msgs(4, 40, cyc);
    chk("rr_cycles", 64'(cyc), 64'd12);
    chk("rr_b0", got[0], 64'h0001); chk("rr_b1", got[1], 64'hA0);
    chk("rr_b2", got[2], 64'h0102); chk("rr_b3", got[3], 64'hF0);
    chk("rr_b4", got[4], 64'h0201); chk("rr_b5", got[5], 64'hA1);
    chk("rr_b6", got[6], 64'h0302); chk("rr_b7", got[7], 64'hF1);

    // Backpressure on header and payload; free entry arriving mid-message must wait
    got.delete();
    pops_a = 0; pops_f = 0;
    aq.push_back(64'hB0B0);
    refresh();
    resp_rdy_i = 1'b0;
    tick(); chk("bp_pop", 64'(s_ra), 64'd1);
    fq.push_back(64'hF00D);
    refresh();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hdr_hold", s_data, 64'h0401); chk("bp_hdr_val", 64'(s_val), 64'd1);
      chk("bp_hdr_nopop", 64'({s_ra, s_rf}), 64'd0);
    end
    resp_rdy_i = 1'b1;
    tick();
    resp_rdy_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_pay_hold", s_data, 64'hB0B0); chk("bp_pay_seq", 64'(s_seq), 64'd4);
      chk("bp_pay_nopop", 64'({s_ra, s_rf}), 64'd0);
    end
    resp_rdy_i = 1'b1;
    tick();
    chk("bp_seq_after", 64'(seq_o), 64'd5);
    chk("bp_hdr", got[0], 64'h0401); chk("bp_payload", got[1], 64'hB0B0);
    run_msgs(2, 20, cyc);
    chk("bp_next_hdr", got[2], 64'h0502); chk("bp_next_payload", got[3], 64'hF00D);
    chk("bp_pops", 64'({pops_a[7:0], pops_f[7:0]}), 64'h0101);

    // Only free non-empty while pointer prefers alloc
    got.delete();
    fq.push_back(64'h77);
    refresh();
    tick(); chk("fo_pop_free", 64'(s_rf), 64'd1); chk("fo_pop_alloc", 64'(s_ra), 64'd0);
    run_msgs(1, 20, cyc);
    chk("fo_hdr", got[0], 64'h0602); chk("fo_payload", got[1], 64'h77);

    // Sequence wrap across 257 messages
    do_reset();
    for (int i = 0; i < 257; i++) aq.push_back(64'(i) + 64'h1_0000);
    refresh();
    run_msgs(257, 900, cyc);
    err = 0;
    for (int i = 0; i < 257; i++) begin
      if (got[2 * i] !== ((64'(i % 256) << 8) | 64'h1)) err++;
      if (got[2 * i + 1] !== 64'(i) + 64'h1_0000) err++;
    end
    chk("wrap_all_beats", 64'(err), 64'd0);
    chk("wrap_hdr_ff", got[510], 64'hFF01);
    chk("wrap_hdr_00", got[512], 64'h0001);
    chk("wrap_seq_after", 64'(seq_o), 64'd1);

    // Asynchronous reset during payload
    got.delete();
    aq.push_back(64'hCAFE);
    refresh();
    tick(); tick();
    chk("ar_in_payload", resp_data_o, 64'hCAFE);
    rst_ni = 1'b0;
    #1;
    chk("ar_val", 64'(resp_val_o), 64'd0); chk("ar_seq", 64'(seq_o), 64'd0);
    chk("ar_busy", 64'(busy_o), 64'd0); chk("ar_data", resp_data_o, 64'd0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    got.delete();
    aq.push_back(64'hA1); fq.push_back(64'hF1);
    refresh();
    run_msgs(2, 20, cyc);
    chk("ar_hdr0", got[0], 64'h0001); chk("ar_pay0", got[1], 64'hA1);
    chk("ar_hdr1", got[2], 64'h0102); chk("ar_pay1", got[3], 64'hF1);

    chk("no_bad_pops", 64'(bad_pop), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
